snes_fb_reader: RTL and testbench
=================================

// Module: snes_fb_reader
// PURPOSE
//  Downstream of the PPU converter: serves the SNES CPU's reads of the converted 8bpp bitplane framebuffer.
//  Double-buffers the framebuffer RAM (converter fills one half, SNES drains the other); swaps halves on SNES release.
//  SNES side is a small register file (address latch, auto-increment data port with prefetch, status/control).
// PARAMETERS
//  RAM_LATENCY  2      cycles from fb_read_address change to valid fb_read_data (1..7)
//  FB_BYTES     32000  bytes per buffer (25x20 tiles x 64 B); data-port address wraps FB_BYTES-1 -> 0
// PORTS
//  clock             in   1   system clock
//  reset             in   1   synchronous, active-high
//  conv_done_tick    in   1   converter finished a frame into write buffer
//  conv_active       in   1   converter busy; swap is forbidden while high
//  write_buffer_sel  out  1   buffer half the converter must write (MSB of its write address)
//  fb_read_address   out  16  {display_buffer, 15-bit byte address} to framebuffer RAM
//  fb_read_data      in   8   framebuffer RAM read data
//  snes_reg          in   3   register select (0 STATUS,1 ADDR_LO,2 ADDR_HI,3 DATA,4 CONTROL,5/6 CSUM_LO/HI)
//  snes_read_strobe  in   1   one-cycle pulse per SNES read (already synchronised)
//  snes_write_strobe in   1   one-cycle pulse per SNES write
//  snes_write_data   in   8   SNES write data
//  snes_read_data    out  8   combinational mux of selected register
//  frame_ready       out  1   a new frame awaits SNES release (also STATUS bit0)
//  debug             out  64  {state, swap count, address, flags}
// BEHAVIOUR
//  Reset: write_buffer_sel=0, display_buffer=1, address=0, frame_ready=0, overrun=0, prefetch=0, state FS_Fetch.
//  STATUS read = {5'b0, overrun, display_buffer, frame_ready}; no side effects.
//  ADDR_LO write: address[7:0]; ADDR_HI write: address[14:8]=data[6:0], then state -> FS_Fetch.
//  Address written >= FB_BYTES: clamp to 0.
//  DATA read returns prefetch register (instant); address <= address+1 (wrap at FB_BYTES) and state -> FS_Fetch.
//  DATA read while state != FS_Valid: return current prefetch, set sticky overrun, still increment and refetch.
//  CONTROL write bit0=release: if swap eligible, swap now; else swap_pending=1.
//  CONTROL write bit1=1 clears overrun.
//  Swap eligible: (frame_ready | conv_done_tick same cycle) & !conv_active.
//  Swap: toggle write_buffer_sel and display_buffer, frame_ready=0, swap_pending=0, address=0, state -> FS_Fetch.
//  swap_pending swap fires on first cycle conv_active=0; release with no frame ready is discarded.
//  conv_done_tick sets frame_ready (unless swapping same cycle).
//  Read and write strobes same cycle: write acts, read returns data but has no side effects.
//  FSM: FS_Fetch loads counter=RAM_LATENCY -> FS_Wait counts down -> at 0 latch fb_read_data into prefetch -> FS_Valid.
//  Any address change during FS_Wait restarts FS_Fetch; stale fetch never lands.
//  Reset mid-fetch: aborts, returns to reset values.
// CONFIGURATION
//  SRT_FB_CHECKSUM_EN defined: 16-bit wrapping sum of every byte returned by DATA reads.
//    Readable at CSUM_LO/HI; cleared on reset, on swap, and on ADDR_HI write.
//  Undefined: no checksum logic; CSUM_LO/HI read 8'h00; all other behaviour identical.
// STRUCTURE
//  Shared package srt_fb_pkg: register-index enum, FS_* state enum, STATUS/CONTROL bit constants.
//  FB_BYTES default also shared with converter.
//  Single module; no sub-module (prefetch FSM is small enough inline).
// TESTING
//  Reset, STATUS read -> 8'h02; write_buffer_sel=0; fb_read_address=16'h8000.
//  ADDR 0x0010, wait RAM_LATENCY+2, 3 DATA reads spaced 5 cycles -> RAM bytes 0x10,0x11,0x12; overrun=0.
//  ADDR 31999, two DATA reads -> bytes 31999 then 0 (wrap).
//  Back-to-back DATA reads 1 cycle apart -> second returns first's byte, STATUS bit2=1; CONTROL 0x02 clears it.
//  done_tick with conv_active=1, release -> no swap; conv_active falls -> swap: write_buffer_sel=1, frame_ready=0, address=0.
//  SRT_FB_CHECKSUM_EN: read bytes 0x01,0xFF,0x10 -> CSUM=0x0110; without macro CSUM reads 0x00.

Source files
------------

// File: rtl/srt_fb_pkg.sv
// Shared definitions for the SNES framebuffer reader and the PPU converter:
// register map, prefetch FSM states, STATUS/CONTROL bit positions and buffer size.
package srt_fb_pkg;

   localparam int FB_BYTES_DEFAULT = 32000;

   typedef enum logic [2:0] {
      REG_STATUS  = 3'd0,
      REG_ADDR_LO = 3'd1,
      REG_ADDR_HI = 3'd2,
      REG_DATA    = 3'd3,
      REG_CONTROL = 3'd4,
      REG_CSUM_LO = 3'd5,
      REG_CSUM_HI = 3'd6
   } snes_reg_t;

   typedef enum logic [1:0] {
      FS_Fetch = 2'd0,
      FS_Wait  = 2'd1,
      FS_Valid = 2'd2
   } fetch_state_t;

   localparam int STATUS_FRAME_READY_BIT = 0;
   localparam int STATUS_DISPLAY_BIT     = 1;
   localparam int STATUS_OVERRUN_BIT     = 2;
   localparam int CONTROL_RELEASE_BIT    = 0;
   localparam int CONTROL_CLR_OVR_BIT    = 1;

   // Data-port increment that wraps the last byte of a buffer back to zero.
   function automatic logic [14:0] fb_addr_inc(input logic [14:0] addr, input logic [14:0] last_addr);
      if (addr >= last_addr) begin
         return 15'd0;
      end else begin
         return addr + 15'd1;
      end
   endfunction

endpackage

// File: rtl/snes_fb_reader.sv
// SNES-side reader of the double-buffered 8bpp framebuffer with prefetching data port.
// Optional feature macro: SRT_FB_CHECKSUM_EN adds a 16-bit sum of all DATA-port bytes.
module snes_fb_reader
   import srt_fb_pkg::*;
#(
   parameter int RAM_LATENCY = 2,
   parameter int FB_BYTES    = FB_BYTES_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        conv_done_tick,
   input  logic        conv_active,
   output logic        write_buffer_sel,
   output logic [15:0] fb_read_address,
   input  logic [7:0]  fb_read_data,
   input  logic [2:0]  snes_reg,
   input  logic        snes_read_strobe,
   input  logic        snes_write_strobe,
   input  logic [7:0]  snes_write_data,
   output logic [7:0]  snes_read_data,
   output logic        frame_ready,
   output logic [63:0] debug
);

   localparam logic [2:0]  LATENCY   = 3'(RAM_LATENCY);
   localparam logic [14:0] LAST_ADDR = 15'(FB_BYTES - 1);

   fetch_state_t state;
   logic [2:0]   counter;
   logic [14:0]  address;
   logic [7:0]   prefetch;
   logic         display_buffer;
   logic         overrun;
   logic         swap_pending;
   logic [15:0]  swap_count;
   logic [15:0]  csum_value;

   snes_reg_t    reg_sel;
   logic         data_read;
   logic         addr_lo_write;
   logic         addr_hi_write;
   logic         release_req;
   logic         clear_overrun;
   logic         have_frame;
   logic         swap_now;
   logic         defer_swap;
   logic [14:0]  addr_candidate;
   logic [14:0]  addr_written;

   // Decode SNES register accesses and the swap decision for this cycle.
   always_comb begin
      reg_sel        = snes_reg_t'(snes_reg);
      data_read      = snes_read_strobe & ~snes_write_strobe & (reg_sel == REG_DATA);
      addr_lo_write  = snes_write_strobe & (reg_sel == REG_ADDR_LO);
      addr_hi_write  = snes_write_strobe & (reg_sel == REG_ADDR_HI);
      release_req    = snes_write_strobe & (reg_sel == REG_CONTROL) & snes_write_data[CONTROL_RELEASE_BIT];
      clear_overrun  = snes_write_strobe & (reg_sel == REG_CONTROL) & snes_write_data[CONTROL_CLR_OVR_BIT];
      have_frame     = frame_ready | conv_done_tick;
      swap_now       = ~conv_active & ((release_req & have_frame) | swap_pending);
      defer_swap     = conv_active & release_req & have_frame;
      if (addr_hi_write) begin
         addr_candidate = {snes_write_data[6:0], address[7:0]};
      end else begin
         addr_candidate = {address[14:8], snes_write_data};
      end
      if (addr_candidate > LAST_ADDR) begin
         addr_written = 15'd0;
      end else begin
         addr_written = addr_candidate;
      end
   end

   // Buffer ownership, address pointer, sticky flags and the prefetch FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= FS_Fetch;
         counter          <= 3'd0;
         address          <= 15'd0;
         prefetch         <= 8'h00;
         write_buffer_sel <= 1'b0;
         display_buffer   <= 1'b1;
         frame_ready      <= 1'b0;
         overrun          <= 1'b0;
         swap_pending     <= 1'b0;
         swap_count       <= 16'd0;
         csum_value       <= 16'd0;
      end else begin
         if (swap_now) begin
            write_buffer_sel <= ~write_buffer_sel;
            display_buffer   <= ~display_buffer;
            frame_ready      <= 1'b0;
            swap_pending     <= 1'b0;
            address          <= 15'd0;
            state            <= FS_Fetch;
            swap_count       <= swap_count + 16'd1;
            csum_value       <= 16'd0;
         end else begin
            if (conv_done_tick) begin
               frame_ready <= 1'b1;
            end
            if (defer_swap) begin
               swap_pending <= 1'b1;
            end
            if (addr_lo_write || addr_hi_write) begin
               // Any pointer move abandons an in-flight fetch so stale data never lands.
               address <= addr_written;
               state   <= FS_Fetch;
               if (addr_hi_write) begin
                  csum_value <= 16'd0;
               end
            end else if (data_read) begin
               address    <= fb_addr_inc(address, LAST_ADDR);
               state      <= FS_Fetch;
               csum_value <= csum_value + {8'h00, prefetch};
               if (state != FS_Valid) begin
                  overrun <= 1'b1;
               end
            end else begin
               case (state)
                  FS_Fetch: begin
                     counter <= LATENCY;
                     state   <= FS_Wait;
                  end
                  FS_Wait: begin
                     if (counter == 3'd0) begin
                        prefetch <= fb_read_data;
                        state    <= FS_Valid;
                     end else begin
                        counter <= counter - 3'd1;
                     end
                  end
                  FS_Valid: begin
                     state <= FS_Valid;
                  end
                  default: begin
                     state <= FS_Fetch;
                  end
               endcase
            end
         end
         if (clear_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   assign fb_read_address = {display_buffer, address};

   // Register read mux; reads never change state here, only the DATA side effects above.
   always_comb begin
      case (reg_sel)
         REG_STATUS:  snes_read_data = {5'b00000, overrun, display_buffer, frame_ready};
         REG_ADDR_LO: snes_read_data = address[7:0];
         REG_ADDR_HI: snes_read_data = {1'b0, address[14:8]};
         REG_DATA:    snes_read_data = prefetch;
         REG_CONTROL: snes_read_data = {6'b000000, swap_pending, 1'b0};
`ifdef SRT_FB_CHECKSUM_EN
         REG_CSUM_LO: snes_read_data = csum_value[7:0];
         REG_CSUM_HI: snes_read_data = csum_value[15:8];
`else
         REG_CSUM_LO: snes_read_data = 8'h00;
         REG_CSUM_HI: snes_read_data = 8'h00;
`endif
         default:     snes_read_data = 8'h00;
      endcase
   end

   assign debug = {6'd0, state, swap_count, 1'b0, address, prefetch,
                   5'd0, counter, 4'd0, swap_pending, overrun, display_buffer, frame_ready};

endmodule

// File: tb/tb_snes_fb_reader.sv
// Scoreboard bench for snes_fb_reader: reads push expected bytes, a monitor compares them.
module tb_snes_fb_reader;
   import srt_fb_pkg::*;

   localparam int LAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        conv_done_tick = 1'b0;
   logic        conv_active = 1'b0;
   logic        write_buffer_sel;
   logic [15:0] fb_read_address;
   logic [7:0]  fb_read_data;
   logic [2:0]  snes_reg = 3'd0;
   logic        snes_read_strobe = 1'b0;
   logic        snes_write_strobe = 1'b0;
   logic [7:0]  snes_write_data = 8'h00;
   logic [7:0]  snes_read_data;
   logic        frame_ready;
   logic [63:0] debug;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   string      name_q[$];
   logic [15:0] pipe[LAT];

   snes_fb_reader #(.RAM_LATENCY(LAT), .FB_BYTES(32000)) dut (
      .clock(clock), .reset(reset), .conv_done_tick(conv_done_tick), .conv_active(conv_active),
      .write_buffer_sel(write_buffer_sel), .fb_read_address(fb_read_address),
      .fb_read_data(fb_read_data), .snes_reg(snes_reg), .snes_read_strobe(snes_read_strobe),
      .snes_write_strobe(snes_write_strobe), .snes_write_data(snes_write_data),
      .snes_read_data(snes_read_data), .frame_ready(frame_ready), .debug(debug)
   );

   always #5 clock = ~clock;

   // RAM model: byte at address a is a[7:0], delivered LAT cycles after the address.
   always @(posedge clock) begin
      pipe[0] <= fb_read_address;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign fb_read_data = pipe[LAT-1][7:0];

   // Monitor: every read strobe pops one expectation.
   always @(negedge clock) begin
      if (snes_read_strobe) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_read: got %02h, no expectation queued", snes_read_data);
         end else begin
            logic [7:0] e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (snes_read_data !== e) begin
               bad++;
               $display("FAIL %s: got %02h expected %02h", n, snes_read_data, e);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] r, input logic [7:0] d);
      snes_reg = r; snes_write_data = d; snes_write_strobe = 1'b1;
      tick();
      snes_write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [2:0] r, input logic [7:0] e, input string n);
      exp_q.push_back(e); name_q.push_back(n);
      snes_reg = r; snes_read_strobe = 1'b1;
      tick();
      snes_read_strobe = 1'b0;
   endtask

   task automatic set_addr(input logic [14:0] a);
      wr(REG_ADDR_LO, a[7:0]);
      wr(REG_ADDR_HI, {1'b0, a[14:8]});
   endtask

   task automatic chk(input string n, input logic [15:0] got, input logic [15:0] e);
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL %s: got %04h expected %04h", n, got, e);
      end
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      tick();
      rd(REG_STATUS, 8'h02, "reset_status");
      chk("reset_wbs", {15'd0, write_buffer_sel}, 16'h0000);
      chk("reset_fbaddr", fb_read_address, 16'h8000);
      chk("reset_frame_ready", {15'd0, frame_ready}, 16'h0000);

      // Sequential reads spaced 5 cycles apart
      set_addr(15'h0010);
      tick(LAT + 6);
      rd(REG_DATA, 8'h10, "seq0"); tick(4);
      rd(REG_DATA, 8'h11, "seq1"); tick(4);
      rd(REG_DATA, 8'h12, "seq2");
      rd(REG_STATUS, 8'h02, "seq_no_overrun");

      // Wrap at last byte, and clamp of out-of-range address
      set_addr(15'd31999);
      tick(LAT + 6);
      rd(REG_DATA, 8'hFF, "wrap_last"); tick(4);
      rd(REG_DATA, 8'h00, "wrap_first");
      wr(REG_ADDR_LO, 8'h05);
      wr(REG_ADDR_HI, 8'h7D);
      rd(REG_ADDR_LO, 8'h00, "clamp_lo");
      rd(REG_ADDR_HI, 8'h00, "clamp_hi");

      // Back-to-back reads raise overrun; CONTROL bit1 clears it
      set_addr(15'h0020);
      tick(LAT + 6);
      rd(REG_DATA, 8'h20, "b2b_first");
      rd(REG_DATA, 8'h20, "b2b_second");
      rd(REG_STATUS, 8'h06, "overrun_set");
      wr(REG_CONTROL, 8'h02);
      rd(REG_STATUS, 8'h02, "overrun_clear");

      // Release while converter busy defers the swap until it goes idle
      conv_active = 1'b1;
      conv_done_tick = 1'b1; tick(); conv_done_tick = 1'b0;
      rd(REG_STATUS, 8'h03, "frame_ready_status");
      wr(REG_CONTROL, 8'h01);
      tick();
      chk("deferred_wbs", {15'd0, write_buffer_sel}, 16'h0000);
      chk("deferred_frame_ready", {15'd0, frame_ready}, 16'h0001);
      conv_active = 1'b0;
      tick();
      chk("swap_wbs", {15'd0, write_buffer_sel}, 16'h0001);
      chk("swap_frame_ready", {15'd0, frame_ready}, 16'h0000);
      chk("swap_fbaddr", fb_read_address, 16'h0000);
      rd(REG_STATUS, 8'h00, "swap_status");

      // Release with no frame is dropped; with a frame and idle converter swaps at once
      wr(REG_CONTROL, 8'h01);
      tick(2);
      chk("no_frame_release", {15'd0, write_buffer_sel}, 16'h0001);
      conv_done_tick = 1'b1; tick(); conv_done_tick = 1'b0;
      wr(REG_CONTROL, 8'h01);
      chk("immediate_swap_wbs", {15'd0, write_buffer_sel}, 16'h0000);
      chk("immediate_swap_fbaddr", fb_read_address, 16'h8000);

      // Simultaneous read and write on DATA: read returns byte, no side effects
      tick(LAT + 6);
      exp_q.push_back(8'h00); name_q.push_back("rw_same_cycle");
      snes_reg = REG_DATA; snes_read_strobe = 1'b1; snes_write_strobe = 1'b1; snes_write_data = 8'hAA;
      tick();
      snes_read_strobe = 1'b0; snes_write_strobe = 1'b0;
      rd(REG_DATA, 8'h00, "after_rw_no_increment");
      rd(REG_STATUS, 8'h02, "after_rw_no_overrun");

      // Checksum of bytes 0x01, 0xFF, 0x10
      set_addr(15'h0000);
      wr(REG_ADDR_LO, 8'h01); tick(LAT + 6);
      rd(REG_DATA, 8'h01, "csum_b0");
      wr(REG_ADDR_LO, 8'hFF); tick(LAT + 6);
      rd(REG_DATA, 8'hFF, "csum_b1");
      wr(REG_ADDR_LO, 8'h10); tick(LAT + 6);
      rd(REG_DATA, 8'h10, "csum_b2");
`ifdef SRT_FB_CHECKSUM_EN
      rd(REG_CSUM_LO, 8'h10, "csum_lo");
      rd(REG_CSUM_HI, 8'h01, "csum_hi");
`else
      rd(REG_CSUM_LO, 8'h00, "csum_lo_absent");
      rd(REG_CSUM_HI, 8'h00, "csum_hi_absent");
`endif

      // Reset in the middle of a fetch
      set_addr(15'h0030);
      reset = 1'b1; tick(); reset = 1'b0;
      tick(LAT + 6);
      rd(REG_STATUS, 8'h02, "midfetch_reset_status");
      rd(REG_DATA, 8'h00, "midfetch_reset_data");
      chk("midfetch_reset_wbs", {15'd0, write_buffer_sel}, 16'h0000);

      tick(2);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pending_expectations: got %0d left expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
